// File: rtl/isdu_control_if.sv
// Control-to-datapath bundle for the LC-3 sequencer.
// master = isdu_control, slave = datapath side.
interface isdu_control_if;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        LD_IR;
    logic        LD_BEN;
    logic        LD_CC;
    logic        LD_REG;
    logic        LD_PC;
    logic        GatePC;
    logic        GateMDR;
    logic        GateALU;
    logic        GateMARMUX;
    logic [1:0]  PCMUX;
    logic [1:0]  ADDR2MUX;
    logic [1:0]  ALUK;
    logic        ADDR1MUX;
    logic        SR1MUX;
    logic        DRMUX;
    logic        SR2MUX;
    logic        MIO_EN;
    logic        Mem_OE;
    logic        Mem_WE;

    modport master (
        input  Run, Continue, IR, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, ADDR2MUX, ALUK, ADDR1MUX, SR1MUX, DRMUX, SR2MUX,
        output MIO_EN, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, IR, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, ADDR2MUX, ALUK, ADDR1MUX, SR1MUX, DRMUX, SR2MUX,
        input  MIO_EN, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/isdu_control.sv
// LC-3 instruction sequencing/decode FSM (Moore).
// Memory states hold for MEM_WAIT+1 cycles via a 3-bit counter.
module isdu_control #(
    parameter int unsigned MEM_WAIT = 2
) (
    input logic            Clk,
    input logic            Reset,
    isdu_control_if.master bus
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S1, S5, S9, S0, S22, S12,
        S4, S21, S6, S25, S27,
        S7, S23, S16, P1, P2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic       mem_st;
    logic       mem_done;
    logic       imm_q;
    logic       unused_ir;

    assign mem_st   = (state == S33) || (state == S25) ||
                      (state == S16);
    assign mem_done = (cnt == WAIT_LAST);
    assign unused_ir = ^{bus.IR[11:6], bus.IR[4:0]};

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= HALTED;
        else        state <= state_nx;
    end

    // Wait counter: zero outside memory states, so each entry starts at 0
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                   cnt <= '0;
        else if (mem_st && !mem_done) cnt <= cnt + 3'd1;
        else                          cnt <= '0;
    end

    // Capture the immediate flag at decode so outputs stay state-only
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)            imm_q <= 1'b0;
        else if (state == S32) imm_q <= bus.IR[5];
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            HALTED: state_nx = bus.Run ? S18 : HALTED;
            S18:    state_nx = S33;
            S33:    state_nx = mem_done ? S35 : S33;
            S35:    state_nx = S32;
            S32: begin
                case (bus.IR[15:12])
                    4'b0001: state_nx = S1;
                    4'b0101: state_nx = S5;
                    4'b1001: state_nx = S9;
                    4'b0000: state_nx = S0;
                    4'b1100: state_nx = S12;
                    4'b0100: state_nx = S4;
                    4'b0110: state_nx = S6;
                    4'b0111: state_nx = S7;
                    4'b1101: state_nx = P1;
                    default: state_nx = S18;
                endcase
            end
            S1, S5, S9: state_nx = S18;
            S0:     state_nx = bus.BEN ? S22 : S18;
            S22:    state_nx = S18;
            S12:    state_nx = S18;
            S4:     state_nx = S21;
            S21:    state_nx = S18;
            S6:     state_nx = S25;
            S25:    state_nx = mem_done ? S27 : S25;
            S27:    state_nx = S18;
            S7:     state_nx = S23;
            S23:    state_nx = S16;
            S16:    state_nx = mem_done ? S18 : S16;
            P1:     state_nx = bus.Continue ? P2 : P1;
            P2:     state_nx = bus.Continue ? P2 : S18;
            default: state_nx = HALTED;
        endcase
    end

    // Output decode from state and wait counter
    always_comb begin
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.ADDR1MUX   = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.DRMUX      = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.MIO_EN     = 1'b0;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;
        unique case (state)
            S18: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.PCMUX  = 2'b10;
                bus.LD_PC  = 1'b1;
            end
            S33, S25: begin
                bus.MIO_EN = 1'b1;
                bus.Mem_OE = 1'b0;
                bus.LD_MDR = mem_done;
            end
            S35: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
            end
            S32: bus.LD_BEN = 1'b1;
            S1, S5, S9: begin
                bus.SR1MUX  = 1'b1;
                bus.SR2MUX  = imm_q;
                bus.ALUK    = (state == S1) ? 2'b00 :
                              (state == S5) ? 2'b01 : 2'b10;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
            end
            S22: begin
                bus.ADDR1MUX = 1'b1;
                bus.ADDR2MUX = 2'b01;
                bus.PCMUX    = 2'b01;
                bus.LD_PC    = 1'b1;
            end
            S12: begin
                bus.SR1MUX   = 1'b1;
                bus.ADDR2MUX = 2'b11;
                bus.PCMUX    = 2'b01;
                bus.LD_PC    = 1'b1;
            end
            S4: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
            end
            S21: begin
                bus.ADDR1MUX = 1'b1;
                bus.PCMUX    = 2'b01;
                bus.LD_PC    = 1'b1;
            end
            S6, S7: begin
                bus.SR1MUX     = 1'b1;
                bus.ADDR2MUX   = 2'b10;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
            end
            S27: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
            end
            S23: begin
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
            end
            S16: bus.Mem_WE = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_isdu_control.sv
// Bench for isdu_control: three instances (MEM_WAIT 0/2/3),
// per-instruction trace model, table rows, reset and PAUSE sequences.
module tb_isdu_control;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       addr1mux, sr1mux, drmux, sr2mux, mio_en, mem_oe, mem_we;
    } ctl_t;

    typedef struct packed {
        logic [15:0] ir;
        logic        ben;
        int          len;
        ctl_t        first;
    } row_t;

    localparam ctl_t DEF = '{mem_oe: 1'b1, mem_we: 1'b1, default: '0};
    localparam ctl_t S18V = '{gate_pc: 1'b1, ld_mar: 1'b1, pcmux: 2'b10,
                              ld_pc: 1'b1, mem_oe: 1'b1, mem_we: 1'b1,
                              default: '0};

    logic        Clk;
    logic        Reset;
    logic        run;
    logic        cont;
    logic        mon_on;
    logic [15:0] prog [128];
    logic        benv [128];
    ctl_t        obs [3];
    int          checks;
    int          fails;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected cycle-by-cycle control words for one fetch+execute
    function automatic void build(input logic [15:0] ir, input logic ben,
                                  input int mw, output ctl_t s [16],
                                  output int n);
        ctl_t v;
        n = 0;
        for (int i = 0; i < 16; i++) s[i] = DEF;
        s[n] = S18V; n++;
        for (int i = 0; i <= mw; i++) begin
            v = DEF; v.mio_en = 1; v.mem_oe = 0; v.ld_mdr = (i == mw);
            s[n] = v; n++;
        end
        v = DEF; v.gate_mdr = 1; v.ld_ir = 1; s[n] = v; n++;
        v = DEF; v.ld_ben = 1; s[n] = v; n++;
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                v = DEF; v.sr1mux = 1; v.sr2mux = ir[5];
                v.aluk = (ir[15:12] == 4'h1) ? 2'd0 :
                         (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
                v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1;
                s[n] = v; n++;
            end
            4'h0: begin
                s[n] = DEF; n++;
                if (ben) begin
                    v = DEF; v.addr1mux = 1; v.addr2mux = 2'b01;
                    v.pcmux = 2'b01; v.ld_pc = 1; s[n] = v; n++;
                end
            end
            4'hC: begin
                v = DEF; v.sr1mux = 1; v.addr2mux = 2'b11;
                v.pcmux = 2'b01; v.ld_pc = 1; s[n] = v; n++;
            end
            4'h4: begin
                v = DEF; v.gate_pc = 1; v.drmux = 1; v.ld_reg = 1;
                s[n] = v; n++;
                v = DEF; v.addr1mux = 1; v.pcmux = 2'b01; v.ld_pc = 1;
                s[n] = v; n++;
            end
            4'h6, 4'h7: begin
                v = DEF; v.sr1mux = 1; v.addr2mux = 2'b10;
                v.gate_marmux = 1; v.ld_mar = 1; s[n] = v; n++;
                if (ir[12] == 1'b0) begin
                    for (int i = 0; i <= mw; i++) begin
                        v = DEF; v.mio_en = 1; v.mem_oe = 0;
                        v.ld_mdr = (i == mw); s[n] = v; n++;
                    end
                    v = DEF; v.gate_mdr = 1; v.ld_reg = 1; v.ld_cc = 1;
                    s[n] = v; n++;
                end else begin
                    v = DEF; v.aluk = 2'b11; v.gate_alu = 1; v.ld_mdr = 1;
                    s[n] = v; n++;
                    for (int i = 0; i <= mw; i++) begin
                        v = DEF; v.mem_we = 0; s[n] = v; n++;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    genvar g;
    for (g = 0; g < 3; g++) begin : gi
        localparam int MW = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        isdu_control_if bus ();
        logic [15:0] ir_r;
        logic        ben_r;
        logic [6:0]  didx;
        logic [6:0]  midx;
        ctl_t        q [$];
        ctl_t        seq [16];
        ctl_t        e;
        int          n;
        int          oe_run;
        int          we_run;

        assign bus.Run      = run;
        assign bus.Continue = cont;
        assign bus.IR       = ir_r;
        assign bus.BEN      = ben_r;

        isdu_control #(.MEM_WAIT(MW)) dut (
            .Clk   (Clk),
            .Reset (Reset),
            .bus   (bus)
        );

        assign obs[g] = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN,
                         bus.LD_CC, bus.LD_REG, bus.LD_PC, bus.GatePC,
                         bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                         bus.PCMUX, bus.ADDR2MUX, bus.ALUK, bus.ADDR1MUX,
                         bus.SR1MUX, bus.DRMUX, bus.SR2MUX, bus.MIO_EN,
                         bus.Mem_OE, bus.Mem_WE};

        // Datapath stand-in: IR and BEN registers fed from the program
        always @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                didx  <= '0;
                ir_r  <= '0;
                ben_r <= 1'b0;
            end else begin
                if (bus.LD_IR) begin
                    ir_r <= prog[didx];
                    didx <= didx + 7'd1;
                end
                if (bus.LD_BEN) ben_r <= benv[didx - 7'd1];
            end
        end

        always @(negedge Clk) begin
            chk($countones({obs[g].gate_pc, obs[g].gate_mdr,
                            obs[g].gate_alu, obs[g].gate_marmux}) <= 1,
                $sformatf("gate_onehot_mw%0d", MW), 32'(obs[g]), 32'(DEF));
            chk(obs[g].mem_oe || obs[g].mem_we,
                $sformatf("strobe_excl_mw%0d", MW), 32'(obs[g]), 32'(DEF));
            if (!mon_on) begin
                q.delete();
                midx   = '0;
                oe_run = 0;
                we_run = 0;
            end else begin
                if (q.size() == 0) begin
                    build(prog[midx], benv[midx], MW, seq, n);
                    for (int i = 0; i < n; i++) q.push_back(seq[i]);
                    midx = midx + 7'd1;
                end
                e = q.pop_front();
                chk(obs[g] == e, $sformatf("trace_mw%0d", MW),
                    32'(obs[g]), 32'(e));
                if (!obs[g].mem_oe) oe_run++;
                else if (oe_run != 0) begin
                    chk(oe_run == MW + 1, $sformatf("oe_len_mw%0d", MW),
                        32'(oe_run), 32'(MW + 1));
                    oe_run = 0;
                end
                if (!obs[g].mem_we) we_run++;
                else if (we_run != 0) begin
                    chk(we_run == MW + 1, $sformatf("we_len_mw%0d", MW),
                        32'(we_run), 32'(MW + 1));
                    we_run = 0;
                end
            end
        end
    end

    function automatic row_t r(input logic [15:0] ir, input logic ben,
                               input int len, input ctl_t f);
        return '{ir, ben, len, f};
    endfunction

    task automatic wait_ben(input string nm);
        int t;
        t = 0;
        while (!obs[1].ld_ben && t < 60) begin
            @(negedge Clk);
            t++;
        end
        chk(t < 60, nm, 32'(t), 32'd60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        row_t        tbl [12];
        ctl_t        first;
        int          n;
        int          t;
        logic [31:0] rv;
        logic [3:0]  op;

        checks = 0;
        fails  = 0;
        Reset  = 1'b0;
        run    = 1'b0;
        cont   = 1'b0;
        mon_on = 1'b0;

        tbl[0]  = r(16'h1261, 1'b0, 1, '{sr1mux: 1'b1, sr2mux: 1'b1,
                    gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[1]  = r(16'h5262, 1'b0, 1, '{sr1mux: 1'b1, sr2mux: 1'b1,
                    aluk: 2'b01, gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[2]  = r(16'h5242, 1'b1, 1, '{sr1mux: 1'b1, aluk: 2'b01,
                    gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[3]  = r(16'h927F, 1'b0, 1, '{sr1mux: 1'b1, sr2mux: 1'b1,
                    aluk: 2'b10, gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[4]  = r(16'h0E05, 1'b1, 2, DEF);
        tbl[5]  = r(16'h0E05, 1'b0, 1, DEF);
        tbl[6]  = r(16'hC1C0, 1'b0, 1, '{sr1mux: 1'b1, addr2mux: 2'b11,
                    pcmux: 2'b01, ld_pc: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[7]  = r(16'h4802, 1'b1, 2, '{gate_pc: 1'b1, drmux: 1'b1,
                    ld_reg: 1'b1, mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[8]  = r(16'h6285, 1'b0, 5, '{sr1mux: 1'b1, addr2mux: 2'b10,
                    gate_marmux: 1'b1, ld_mar: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[9]  = r(16'h7285, 1'b1, 5, '{sr1mux: 1'b1, addr2mux: 2'b10,
                    gate_marmux: 1'b1, ld_mar: 1'b1,
                    mem_oe: 1'b1, mem_we: 1'b1, default: '0});
        tbl[10] = r(16'hF025, 1'b0, 0, S18V);
        tbl[11] = r(16'h2000, 1'b1, 0, S18V);

        for (int i = 0; i < 128; i++) begin
            if (i < 12) begin
                prog[i] = tbl[i].ir;
                benv[i] = tbl[i].ben;
            end else begin
                rv = $urandom();
                op = rv[15:12];
                if (op == 4'hD) op = 4'h1;
                prog[i] = {op, rv[11:0]};
                benv[i] = rv[20];
            end
        end

        #3;
        for (int k = 0; k < 3; k++)
            chk(obs[k] == DEF, $sformatf("reset_out%0d", k),
                32'(obs[k]), 32'(DEF));
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk(obs[1] == DEF, "halted_idle", 32'(obs[1]), 32'(DEF));

        run = 1'b1;
        @(posedge Clk);
        #1;
        run    = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wait_ben($sformatf("row%0d_decode_seen", i));
            @(negedge Clk);
            first = obs[1];
            n = 0;
            while (!(obs[1].gate_pc && obs[1].ld_mar) && n < 20) begin
                n++;
                @(negedge Clk);
            end
            chk(first == tbl[i].first, $sformatf("row%0d_first", i),
                32'(first), 32'(tbl[i].first));
            chk(n == tbl[i].len, $sformatf("row%0d_len", i),
                32'(n), 32'(tbl[i].len));
        end

        repeat (400) begin
            @(negedge Clk);
            run = 1'($urandom_range(0, 1));
        end
        run = 1'b0;

        @(posedge Clk);
        #1;
        mon_on = 1'b0;
        t = 0;
        @(negedge Clk);
        while (!(obs[1].mio_en && !obs[1].mem_oe) && t < 60) begin
            @(negedge Clk);
            t++;
        end
        chk(t < 60, "find_read", 32'(t), 32'd60);
        #2;
        Reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk(obs[k] == DEF, $sformatf("async_reset%0d", k),
                32'(obs[k]), 32'(DEF));
        prog[0] = 16'hD000;
        prog[1] = 16'hD000;
        prog[2] = 16'h1261;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk(obs[1] == DEF, "halted_after_reset", 32'(obs[1]), 32'(DEF));
        run = 1'b1;
        @(posedge Clk);
        #1;
        run = 1'b0;
        @(negedge Clk);
        chk(obs[1] == S18V, "run_start", 32'(obs[1]), 32'(S18V));

        wait_ben("pause1_decode_seen");
        repeat (5) begin
            @(negedge Clk);
            chk(obs[1] == DEF, "p1_hold", 32'(obs[1]), 32'(DEF));
        end
        cont = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            chk(obs[1] == DEF, "p2_hold", 32'(obs[1]), 32'(DEF));
        end
        cont = 1'b0;
        @(negedge Clk);
        chk(obs[1] == S18V, "pause_release", 32'(obs[1]), 32'(S18V));

        wait_ben("pause2_decode_seen");
        repeat (4) begin
            @(negedge Clk);
            chk(obs[1] == DEF, "pause2_hold", 32'(obs[1]), 32'(DEF));
        end
        cont = 1'b1;
        @(negedge Clk);
        chk(obs[1] == DEF, "pause2_p2", 32'(obs[1]), 32'(DEF));
        cont = 1'b0;
        @(negedge Clk);
        chk(obs[1] == S18V, "pause2_release", 32'(obs[1]), 32'(S18V));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/isdu_control.md
# isdu_control

Instruction sequencing and decode unit for the LC-3 datapath. A Moore state machine steps through the fetch → decode → execute sequence: it drives every load, gate and mux select of the datapath, plus the active-low SRAM strobes. It consumes `IR` and `BEN` back from the datapath. Memory accesses take a parameterised number of wait cycles, counted internally.

## Interface
- `MEM_WAIT`, default 2: wait cycles before the data cycle of each memory read/write (legal 0–7).
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
- `Run` in 1: start execution from HALTED.
- `Continue` in 1: releases a PAUSE instruction.
- `IR` in 16: instruction register from the datapath.
- `BEN` in 1: registered branch-enable from the datapath.
- `LD_MAR`, `LD_MDR`, `LD_IR`, `LD_BEN`, `LD_CC`, `LD_REG`, `LD_PC` out 1 each: register loads.
- `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX` out 1 each: bus drivers, at most one high per cycle.
- `PCMUX` out 2: 00 BUS, 01 adder, 10 PC+1.
- `ADDR2MUX` out 2: 00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero.
- `ALUK` out 2: 00 ADD, 01 AND, 10 NOT A, 11 PASS A.
- `ADDR1MUX` out 1: 0 SR1, 1 PC.
- `SR1MUX` out 1: 0 IR[11:9], 1 IR[8:6].
- `DRMUX` out 1: 0 IR[11:9], 1 R7.
- `SR2MUX` out 1: 0 SR2 register, 1 SEXT5 immediate.
- `MIO_EN` out 1: 0 MDR loads from BUS, 1 MDR loads from memory.
- `Mem_OE`, `Mem_WE` out 1 each: SRAM output/write enable, active-low.

## Operation
- Outputs are a pure decode of state plus the wait counter; they never depend combinationally on inputs.
- **Default output values:** all LD/Gate 0, all selects 0, `Mem_OE`=`Mem_WE`=1. Each state lists only its deviations.
- **HALTED:** go to S18 when `Run`=1.
- **S18:** `GatePC`, `LD_MAR`, `PCMUX`=10, `LD_PC`. Go to S33.
- **S33 (read):** `MIO_EN`=1, `Mem_OE`=0 for MEM_WAIT+1 cycles. `LD_MDR` only in the final cycle. Go to S35.
- **S35:** `GateMDR`, `LD_IR`. Go to S32.
- **S32:** `LD_BEN`. Dispatch on IR[15:12].
- **ADD 0001 / AND 0101 / NOT 1001:**
  - Outputs: `SR1MUX`=1, `DRMUX`=0, `SR2MUX`=IR[5], `ALUK`=00/01/10, `GateALU`, `LD_REG`, `LD_CC`.
  - Next state: S18.
- **BR 0000 (S0):** go to S22 if `BEN`, else S18.
  - S22: `ADDR1MUX`=1, `ADDR2MUX`=01, `PCMUX`=01, `LD_PC`. Go to S18.
- **JMP 1100 (S12):** `SR1MUX`=1, `ADDR1MUX`=0, `ADDR2MUX`=11, `PCMUX`=01, `LD_PC`. Go to S18.
- **JSR 0100:**
  - S4: `GatePC`, `DRMUX`=1, `LD_REG`. Go to S21.
  - S21: `ADDR1MUX`=1, `ADDR2MUX`=00, `PCMUX`=01, `LD_PC`. Go to S18.
  - IR[11] is ignored; JSRR is not supported.
- **LDR 0110:**
  - S6: `SR1MUX`=1, `ADDR1MUX`=0, `ADDR2MUX`=10, `GateMARMUX`, `LD_MAR`. Go to S25.
  - S25: same as S33. Go to S27.
  - S27: `GateMDR`, `DRMUX`=0, `LD_REG`, `LD_CC`. Go to S18.
- **STR 0111:**
  - S7: same as S6. Go to S23.
  - S23: `SR1MUX`=0, `ALUK`=11, `GateALU`, `MIO_EN`=0, `LD_MDR`. Go to S16.
  - S16: `Mem_WE`=0 for MEM_WAIT+1 cycles. Go to S18.
- **PAUSE 1101:**
  - P1: hold until `Continue`=1, then go to P2.
  - P2: hold until `Continue`=0, then go to S18. Exactly one instruction is released per `Continue` pulse.
- **Any other opcode:** NOP, go to S18.
- **`Run` after start:** ignored outside HALTED. There is no return to HALTED except via `Reset`.

## Timing
- **Reset assertion:** state becomes HALTED and the wait counter 0, asynchronously. All outputs go to their default values immediately, including deassertion of `Mem_OE`/`Mem_WE` mid-access.
- **Reset release:** the first transition can occur at the first `Clk` edge after `Reset` goes high.
- **Wait counter:** 3 bits; clears on entry to each memory state; the state exits when count equals MEM_WAIT. With MEM_WAIT=0 each memory state lasts one cycle.
- **Fetch + decode:** MEM_WAIT+4 cycles (6 cycles at the default).
- **Execute length:**
  - ADD/AND/NOT/JMP: 1 cycle.
  - BR not taken: 1 cycle; BR taken: 2.
  - JSR: 2.
  - LDR/STR: MEM_WAIT+3.
  - PAUSE: unbounded.
- **BEN timing:** `BEN` is sampled in S0, one cycle after the `LD_BEN` cycle, so it reflects the new IR.
- **Strobe stability:** `Mem_OE`/`Mem_WE` are stable for the full memory state and never low simultaneously.

## Test plan
- **Reset/run:** Reset low mid-S33 → `Mem_OE`=1 within the same cycle, state HALTED. Release, `Run`=1 → S18 next edge with `GatePC`=`LD_MAR`=`LD_PC`=1 and `PCMUX`=10.
- **ADD:** IR=0x1261 (ADD R1,R1,#1), MEM_WAIT=2 → 7 cycles S18…S1. In S1: `SR2MUX`=1, `SR1MUX`=1, `ALUK`=00, `LD_REG`=`LD_CC`=1.
- **BR:**
  - IR=0x0E05 with `BEN`=1 → S22 with `ADDR2MUX`=01, `PCMUX`=01.
  - With `BEN`=0 → S18 directly after S0.
- **LDR/STR with MEM_WAIT=0 and 3:**
  - `Mem_OE`=0 low for exactly 1 and 4 cycles respectively.
  - STR: `Mem_WE`=0 for the same counts.
  - STR S23: `ALUK`=11 and `MIO_EN`=0.
- **JSR:** IR=0x4802 → S4 (`DRMUX`=1, `GatePC`), then S21 (`ADDR2MUX`=00, `ADDR1MUX`=1), then S18.
- **PAUSE and illegal opcode:**
  - IR=0xD000: holds in P1 while `Continue`=0; `Continue` high 5 cycles holds in P2; the fall → S18.
  - IR=0xF025 → S18 with no LD asserted.
- **Every cycle, all tests:** assert at most one Gate high.
